averaging_filter: RTL and testbench

//   N-tap moving-average (boxcar FIR) filter for the signed 24-bit audio path.
//   It is the receive end of the noise injected upstream: it sits between the

---
 rtl/avg_filter_pkg.sv | 23 ++
 rtl/sample_delay_line.sv | 51 +++++
 rtl/averaging_filter.sv | 159 +++++++++++++++
 tb/tb_averaging_filter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/avg_filter_pkg.sv
// -----------------------------------------------------------------------------
// avg_filter_pkg
//   Shared types and defaults for the moving-average filter on the signed
//   24-bit audio path.
//   Contents:
//     DEF_DATA_W  - default sample width (two's complement)
//     DEF_LOG2_N  - default log2 of the tap count (N = 8)
//     sample_t    - signed sample at the default width
//     avg_state_t - filter state: FILL (history still filling) -> RUN
// -----------------------------------------------------------------------------
package avg_filter_pkg;

    localparam int DEF_DATA_W = 24;
    localparam int DEF_LOG2_N = 3;

    typedef logic signed [DEF_DATA_W-1:0] sample_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } avg_state_t;

endpackage : avg_filter_pkg

// File: rtl/sample_delay_line.sv
// -----------------------------------------------------------------------------
// sample_delay_line
//   N-entry circular history of the most recent samples (N = 2**LOG2_N).
//   'oldest' is the entry the next write will overwrite, i.e. the sample that
//   leaves the averaging window when a new one enters.
//   Ports:
//     clk      in   1       system clock, posedge
//     reset_n  in   1       asynchronous active-low clear of buffer and pointer
//     clear    in   1       synchronous clear of buffer and pointer
//     wr_en    in   1       write wr_data at the pointer and advance it
//     wr_data  in   DATA_W  sample to store
//     oldest   out  DATA_W  hist[wptr], combinational
// -----------------------------------------------------------------------------
module sample_delay_line #(
    parameter int DATA_W = 24,
    parameter int LOG2_N = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic signed [DATA_W-1:0] wr_data,
    output logic signed [DATA_W-1:0] oldest
);

    localparam int N = 1 << LOG2_N;

    logic signed [DATA_W-1:0] hist [N];
    logic [LOG2_N-1:0]        wptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                hist[i] <= '0;
            end
            wptr <= '0;
        end else if (clear) begin
            for (int i = 0; i < N; i++) begin
                hist[i] <= '0;
            end
            wptr <= '0;
        end else if (wr_en) begin
            hist[wptr] <= wr_data;
            // N is a power of two, so the pointer wraps on its own.
            wptr       <= wptr + 1'b1;
        end
    end

    assign oldest = hist[wptr];

endmodule : sample_delay_line

// File: rtl/averaging_filter.sv
// -----------------------------------------------------------------------------
// averaging_filter
//   N-tap moving-average (boxcar) filter between CODEC read data and CODEC
//   write data. Advances one sample per enable strobe and removes periodic
//   disturbances that sum to zero over N samples.
//
//   Build option:
//     AVG_ROUND_EN  defined   -> data_out = (sum + N/2) >>> LOG2_N (half up)
//                   undefined -> data_out = sum >>> LOG2_N (toward -inf)
//
//   Ports:
//     clk         in   1       system clock, posedge
//     reset_n     in   1       asynchronous active-low reset
//     enable      in   1       sample strobe
//     clear       in   1       synchronous flush of history and outputs
//     data_in     in   DATA_W  signed input sample
//     data_out    out  DATA_W  signed average, registered
//     valid_out   out  1       N samples accumulated since reset/clear
//     out_strobe  out  1       data_out was updated this cycle
//     dbg_state   out  1       current avg_state_t (0 = FILL, 1 = RUN)
//
//   Handshake: enable is a push-only strobe with no back-pressure. Every
//   cycle with enable=1 and clear=0 consumes data_in; the result appears on
//   data_out one cycle later together with a one-cycle out_strobe. Back-to-
//   back enables are accepted at one sample per cycle. clear beats enable.
// -----------------------------------------------------------------------------
module averaging_filter
    import avg_filter_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LOG2_N = DEF_LOG2_N
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] data_in,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     valid_out,
    output logic                     out_strobe,
    output logic                     dbg_state
);

    localparam int N  = 1 << LOG2_N;
    // Sum of N DATA_W-bit samples needs exactly LOG2_N extra bits.
    localparam int AW = DATA_W + LOG2_N;

    localparam logic [LOG2_N-1:0] FILL_LAST = LOG2_N'(N - 1);

    avg_state_t               state_q, state_d;
    logic [LOG2_N-1:0]        fill_q, fill_d;
    logic signed [AW-1:0]     acc_q, acc_next;
    logic signed [AW-1:0]     din_ext, old_ext;
    logic signed [DATA_W-1:0] oldest;
    logic signed [DATA_W-1:0] avg;
    logic                     take;

    // A sample enters the window only when it is not discarded by clear.
    assign take = enable & ~clear;

    sample_delay_line #(
        .DATA_W (DATA_W),
        .LOG2_N (LOG2_N)
    ) u_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .wr_en   (take),
        .wr_data (data_in),
        .oldest  (oldest)
    );

    // Running sum: add the new sample, drop the one leaving the window.
    // With zero history during FILL this yields the intended ramp.
    assign din_ext  = {{LOG2_N{data_in[DATA_W-1]}}, data_in};
    assign old_ext  = {{LOG2_N{oldest[DATA_W-1]}}, oldest};
    assign acc_next = acc_q + din_ext - old_ext;

`ifdef AVG_ROUND_EN
    localparam logic signed [AW:0] ROUND_HALF = (AW + 1)'(1 << (LOG2_N - 1));

    logic signed [AW:0] rnd_sum;
    logic               unused_rnd_bits;

    // One extra bit so adding N/2 to the largest sum cannot wrap. After the
    // divide the result always fits DATA_W again, so the top and the
    // fractional bits are discarded.
    assign rnd_sum         = {acc_next[AW-1], acc_next} + ROUND_HALF;
    assign avg             = rnd_sum[AW-1:LOG2_N];
    assign unused_rnd_bits = ^{rnd_sum[AW], rnd_sum[LOG2_N-1:0]};
`else
    // Dropping the low LOG2_N bits of a signed sum is an arithmetic shift.
    assign avg = acc_next[AW-1:LOG2_N];
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FILL;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    // fill_q counts samples already in the window during FILL; the enable
    // seen while it reads N-1 is the Nth sample and completes the window.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        if (clear) begin
            state_d = FILL;
            fill_d  = '0;
        end else if (enable) begin
            case (state_q)
                FILL: begin
                    if (fill_q == FILL_LAST) begin
                        state_d = RUN;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                RUN: begin
                    fill_d = fill_q;
                end
                default: begin
                    state_d = FILL;
                    fill_d  = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------ datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q      <= '0;
            data_out   <= '0;
            out_strobe <= 1'b0;
        end else if (clear) begin
            acc_q      <= '0;
            data_out   <= '0;
            out_strobe <= 1'b0;
        end else if (enable) begin
            acc_q      <= acc_next;
            data_out   <= avg;
            out_strobe <= 1'b1;
        end else begin
            out_strobe <= 1'b0;
        end
    end

    // The state register moves to RUN on the same edge that loads the Nth
    // average, so valid_out rises with that sample's data_out.
    assign valid_out = (state_q == RUN);
    assign dbg_state = state_q;

endmodule : averaging_filter

// File: tb/tb_averaging_filter.sv
module tb_averaging_filter;
  import avg_filter_pkg::*;

  localparam int DATA_W = DEF_DATA_W;
  localparam int LOG2_N = DEF_LOG2_N;
  localparam int N      = 1 << LOG2_N;

  // ------------------------------------------------ clock / reset block
  logic clk;
  logic reset_n;
  logic enable;
  logic clear;
  logic signed [DATA_W-1:0] data_in;
  logic signed [DATA_W-1:0] data_out;
  logic valid_out;
  logic out_strobe;
  logic dbg_state;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  averaging_filter #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .clear      (clear),
    .data_in    (data_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .out_strobe (out_strobe),
    .dbg_state  (dbg_state)
  );

  // ------------------------------------------------ scoreboard
  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: the window is simply the list of the last N accepted
  // samples (missing ones count as zero); the output is floor(sum / N), or
  // floor((sum + N/2) / N) with rounding.
  int     win_q[$];
  int     n_seen;
  longint m_data;
  bit     m_strobe;

  function automatic longint floor_div(input longint num, input longint den);
    longint q;
    q = num / den;
    if ((num % den != 0) && (num < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint window_avg();
    longint s;
    s = 0;
    foreach (win_q[i]) s += win_q[i];
`ifdef AVG_ROUND_EN
    s += N / 2;
`endif
    return floor_div(s, N);
  endfunction

  task automatic model_reset();
    win_q.delete();
    n_seen   = 0;
    m_data   = 0;
    m_strobe = 0;
  endtask

  task automatic model_apply(input bit en, input bit clr, input int d);
    if (clr) begin
      model_reset();
    end else if (en) begin
      win_q.push_back(d);
      if (win_q.size() > N) void'(win_q.pop_front());
      n_seen++;
      m_data   = window_avg();
      m_strobe = 1;
    end else begin
      m_strobe = 0;
    end
  endtask

  task automatic compare_outputs(input string tag);
    sample_t exp_s;
    bit      exp_valid;
    exp_q.push_back(DATA_W'(m_data));
    exp_s     = exp_q.pop_front();
    exp_valid = (n_seen >= N);
    check({tag, ".data"},   data_out,   exp_s);
    check({tag, ".valid"},  valid_out,  exp_valid);
    check({tag, ".strobe"}, out_strobe, m_strobe);
    check({tag, ".state"},  dbg_state,  exp_valid);
  endtask

  // ------------------------------------------------ driver tasks
  // One clock of stimulus: drive on the falling edge, sample 1 ns after
  // the rising edge.
  task automatic step(input string tag, input bit en, input bit clr, input int d);
    @(negedge clk);
    enable  = en;
    clear   = clr;
    data_in = DATA_W'(d);
    @(posedge clk);
    #1;
    model_apply(en, clr, d);
    compare_outputs(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 0);
  endtask

  // ------------------------------------------------ stimulus
  initial begin
    int d;
    bit en, clr;

    reset_n = 1'b0;
    enable  = 1'b0;
    clear   = 1'b0;
    data_in = '0;
    model_reset();
    #35;
    check("reset.data",   data_out,   0);
    check("reset.valid",  valid_out,  0);
    check("reset.strobe", out_strobe, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Test 1: constant 800 ramps 100..800, valid with the 8th.
    for (int i = 0; i < N; i++) begin
      step("t1", 1'b1, 1'b0, 800);
      check("t1.ramp", data_out, 100 * (i + 1));
    end
    check("t1.valid_last", valid_out, 1);
    idle("t1.idle");
    check("t1.hold", data_out, 800);

    // Test 2: 8-step sawtooth noise averages to -1024.
    step("t2.clr", 1'b0, 1'b1, 0);
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < N; k++) begin
        d = ((k < 4) ? k : k - 8) * 2048;
        step("t2", 1'b1, 1'b0, d);
        if (p > 0 || k == N - 1) check("t2.const", data_out, -1024);
      end
    end

    // Test 3: clear together with enable discards the sample.
    for (int i = 0; i < N; i++) step("t3.fill", 1'b1, 1'b0, 800);
    step("t3.clr", 1'b1, 1'b1, 5000);
    check("t3.clr_data",  data_out,  0);
    check("t3.clr_valid", valid_out, 0);
    step("t3.after", 1'b1, 1'b0, 800);
    check("t3.after_data", data_out, 100);

    // Test 4: small values expose truncation vs rounding.
    step("t4.clr", 1'b0, 1'b1, 0);
    step("t4.seven", 1'b1, 1'b0, 7);
`ifdef AVG_ROUND_EN
    check("t4.seven_val", data_out, 1);
`else
    check("t4.seven_val", data_out, 0);
`endif
    for (int i = 0; i < N - 1; i++) step("t4.zero", 1'b1, 1'b0, 0);
    for (int i = 0; i < N; i++) step("t4.neg1", 1'b1, 1'b0, -1);
    check("t4.neg1_val", data_out, -1);

    // Test 5: most-negative sample, 16 back-to-back enables.
    step("t5.clr", 1'b0, 1'b1, 0);
    for (int i = 0; i < 2 * N; i++) step("t5", 1'b1, 1'b0, -8388608);
    check("t5.settle", data_out, -8388608);

    // Randomized traffic with sparse clears.
    for (int i = 0; i < 400; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 39) == 0);
      d   = int'($urandom) >>> (32 - DATA_W);
      if ($urandom_range(0, 9) == 0) d = ($urandom_range(0, 1) != 0) ? 8388607 : -8388608;
      step("rand", en, clr, d);
    end

    // Test 6: asynchronous reset between edges.
    for (int i = 0; i < N; i++) step("t6.fill", 1'b1, 1'b0, 800);
    @(posedge clk);
    #4;
    reset_n = 1'b0;
    #1;
    check("t6.async_data",   data_out,   0);
    check("t6.async_valid",  valid_out,  0);
    check("t6.async_strobe", out_strobe, 0);
    model_reset();
    @(negedge clk);
    enable  = 1'b0;
    reset_n = 1'b1;
    step("t6.first", 1'b1, 1'b0, 800);
    check("t6.first_data", data_out, 100);

    idle("end");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_averaging_filter
